// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer that shares one memory port among four requesters.
// Each grant runs through issue (valid/ready) and wait (done or timeout), then returns a pulse to the owner.
module mem_port_arbiter #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] req_i,
  input  logic [3:0] req_lock_i,
  output logic [1:0] sel_o,
  output logic [3:0] gnt_o,
  output logic       mem_valid_o,
  input  logic       mem_ready_i,
  input  logic       mem_done_i,
  output logic [3:0] done_o,
  output logic [3:0] err_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  localparam logic [TIMEOUT_W-1:0] CntMax  = '1;
  localparam logic [TIMEOUT_W-1:0] CntLast = TIMEOUT_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [3:0]           gnt_q, gnt_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [3:0]           done_q, done_d;
  logic [3:0]           err_q, err_d;

  logic                 found;
  logic [1:0]           winner;
  logic [1:0]           idx;
  logic                 relEn;
  logic                 timeoutHit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // A disabled timeout (TIMEOUT == 0) never fires; the counter still saturates harmlessly.
  assign timeoutHit = (TIMEOUT != 0) && (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = '0;
    err_d   = '0;
    found   = 1'b0;
    winner  = ptr_q;
    idx     = ptr_q;
    relEn   = 1'b0;

    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
          sel_d   = winner;
          gnt_d   = 4'b0001 << winner;
        end
      end
      ISSUE: begin
        if (mem_ready_i) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (cnt_q != CntMax) cnt_d = cnt_q + TIMEOUT_W'(1);
        if (mem_done_i) begin
          done_d = gnt_q;
          relEn  = 1'b1;
        end else if (timeoutHit) begin
          err_d = gnt_q;
          relEn = 1'b1;
        end
        // A locked owner re-issues directly, keeping the rotation pointer where it was.
        if (relEn) begin
          if (req_lock_i[sel_q] && req_i[sel_q]) begin
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = sel_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel_o       = sel_q;
  assign gnt_o       = gnt_q;
  assign mem_valid_o = (state_q == ISSUE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; completion pulses are checked against a scoreboard of expected owners.
module tb_mem_port_arbiter;

  localparam int TimeoutTb = 4;

  logic       clk;
  logic       rstN;
  logic [3:0] req;
  logic [3:0] reqLock;
  logic [1:0] selO;
  logic [3:0] gntO;
  logic       memValidO;
  logic       memReady;
  logic       memDone;
  logic [3:0] doneO;
  logic [3:0] errO;
  logic       busyO;

  typedef struct {
    logic [1:0] owner;
    logic       isErr;
  } exp_t;

  exp_t sb[$];
  exp_t monE;
  int   checks   = 0;
  int   failures = 0;

  mem_port_arbiter #(.TIMEOUT_W(8), .TIMEOUT(TimeoutTb)) dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .req_i      (req),
    .req_lock_i (reqLock),
    .sel_o      (selO),
    .gnt_o      (gntO),
    .mem_valid_o(memValidO),
    .mem_ready_i(memReady),
    .mem_done_i (memDone),
    .done_o     (doneO),
    .err_o      (errO),
    .busy_o     (busyO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Any done/err pulse must match the oldest expected completion; a stray pulse is a failure.
  always @(negedge clk) begin
    if (doneO !== 4'b0000 || errO !== 4'b0000) begin
      if (sb.size() == 0) begin
        checkOutput("strayPulse", {24'h0, doneO, errO}, 32'h0);
      end else begin
        monE = sb.pop_front();
        checkOutput("doneVec", 32'(doneO), monE.isErr ? 32'h0 : (32'h1 << monE.owner));
        checkOutput("errVec",  32'(errO),  monE.isErr ? (32'h1 << monE.owner) : 32'h0);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] expOwner, input int readyDelay, input int doneDelay,
                               input bit expectErr, input bit expectLock);
    int guard = 0;
    while (memValidO !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    checkOutput("issueSeen", 32'(memValidO), 32'h1);
    checkOutput("sel", 32'(selO), 32'(expOwner));
    checkOutput("gnt", 32'(gntO), 32'h1 << expOwner);
    checkOutput("busyIssue", 32'(busyO), 32'h1);
    for (int i = 0; i < readyDelay; i++) begin
      step();
      checkOutput("stallValid", 32'(memValidO), 32'h1);
      checkOutput("stallSel", 32'(selO), 32'(expOwner));
    end
    memReady = 1'b1;
    step();
    memReady = 1'b0;
    checkOutput("waitValid", 32'(memValidO), 32'h0);
    checkOutput("waitGnt", 32'(gntO), 32'h1 << expOwner);
    if (expectErr) begin
      sb.push_back('{expOwner, 1'b1});
      repeat (TimeoutTb) step();
    end else begin
      repeat (doneDelay) step();
      sb.push_back('{expOwner, 1'b0});
      memDone = 1'b1;
      step();
      memDone = 1'b0;
    end
    checkOutput("relValid", 32'(memValidO), 32'(expectLock));
    checkOutput("relGnt", 32'(gntO), expectLock ? (32'h1 << expOwner) : 32'h0);
    checkOutput("relSel", 32'(selO), 32'(expOwner));
  endtask

  task automatic resetPulse();
    rstN = 1'b0;
    step();
    step();
    rstN = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstN     = 1'b0;
    req      = '0;
    reqLock  = '0;
    memReady = 1'b0;
    memDone  = 1'b0;
    #1;
    checkOutput("rstSel", 32'(selO), 32'h0);
    checkOutput("rstGnt", 32'(gntO), 32'h0);
    checkOutput("rstValid", 32'(memValidO), 32'h0);
    checkOutput("rstDone", 32'(doneO), 32'h0);
    checkOutput("rstErr", 32'(errO), 32'h0);
    checkOutput("rstBusy", 32'(busyO), 32'h0);
    step();
    step();
    rstN = 1'b1;

    // Single request from owner 2 with one stall cycle.
    req = 4'b0100;
    applyStimulus(2'd2, 1, 2, 1'b0, 1'b0);
    req = 4'b0000;
    checkOutput("idleBusy", 32'(busyO), 32'h0);
    step();
    checkOutput("idleStay", 32'(busyO), 32'h0);

    // Fairness from a freshly reset pointer.
    resetPulse();
    req = 4'b1111;
    applyStimulus(2'd0, 0, 0, 1'b0, 1'b0);
    applyStimulus(2'd1, 0, 0, 1'b0, 1'b0);
    applyStimulus(2'd2, 0, 0, 1'b0, 1'b0);
    applyStimulus(2'd3, 0, 0, 1'b0, 1'b0);
    applyStimulus(2'd0, 0, 0, 1'b0, 1'b0);
    req = 4'b0000;

    // Locked owner 1 keeps the port; after unlocking, the scan starts at 2 and lands on 0.
    req     = 4'b0011;
    reqLock = 4'b0010;
    applyStimulus(2'd1, 0, 0, 1'b0, 1'b1);
    applyStimulus(2'd1, 0, 1, 1'b0, 1'b1);
    reqLock = 4'b0000;
    applyStimulus(2'd1, 0, 0, 1'b0, 1'b0);
    req = 4'b0001;
    applyStimulus(2'd0, 0, 0, 1'b0, 1'b0);
    req = 4'b0000;

    // Timeout, then completion on the last allowed wait cycle.
    req = 4'b1000;
    applyStimulus(2'd3, 0, 0, 1'b1, 1'b0);
    applyStimulus(2'd3, 0, TimeoutTb - 1, 1'b0, 1'b0);
    req = 4'b0000;

    // Long ready stall never times out.
    req = 4'b0001;
    applyStimulus(2'd0, 10, 0, 1'b0, 1'b0);
    req = 4'b0000;

    // Asynchronous reset in the middle of a wait.
    req = 4'b0010;
    begin
      int guard = 0;
      while (memValidO !== 1'b1 && guard < 20) begin
        step();
        guard++;
      end
    end
    checkOutput("t1Sel", 32'(selO), 32'h1);
    memReady = 1'b1;
    step();
    memReady = 1'b0;
    step();
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t1Sel0", 32'(selO), 32'h0);
    checkOutput("t1Gnt0", 32'(gntO), 32'h0);
    checkOutput("t1Valid0", 32'(memValidO), 32'h0);
    checkOutput("t1Done0", 32'(doneO), 32'h0);
    checkOutput("t1Err0", 32'(errO), 32'h0);
    checkOutput("t1Busy0", 32'(busyO), 32'h0);
    req = 4'b0000;
    step();
    step();
    rstN = 1'b1;
    repeat (6) step();
    checkOutput("t1Idle", 32'(busyO), 32'h0);
    req = 4'b1111;
    applyStimulus(2'd0, 0, 0, 1'b0, 1'b0);
    req = 4'b0000;
    step();
    step();
    checkOutput("sbEmpty", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
